apb_master_bridge: RTL
======================

// Module: apb_master_bridge
// PURPOSE
//  Upstream APB requester: turns a valid/ready command stream into APB SETUP/ACCESS transfers on
//  apb_if signals, then returns read data and status on a valid/ready response channel.
//  Handles pready wait states, pslverr, and a bounded-wait timeout.
//  One transfer in flight; psel always drops between transfers, so every transfer starts with a rising psel.
// PARAMETERS
//  ADDR_W   8   width of req_addr / paddr
//  DATA_W   32  width of wdata / rdata
//  TIMEOUT  16  max ACCESS cycles before abort; 0 = never time out
// PORTS
//  pclk         in   1       clock; all logic on rising edge
//  preset       in   1       asynchronous, active-high reset
//  req_valid    in   1       command valid
//  req_ready    out  1       command accepted when valid&ready
//  req_write    in   1       1=write, 0=read
//  req_addr     in   ADDR_W  transfer address
//  req_wdata    in   DATA_W  write data (ignored for reads)
//  rsp_valid    out  1       response valid; held until rsp_ready
//  rsp_ready    in   1       response consumed when valid&ready
//  rsp_rdata    out  DATA_W  read data; 0 for writes and timeouts
//  rsp_err      out  1       pslverr seen or timeout
//  rsp_timeout  out  1       transfer aborted by timeout
//  paddr        out  ADDR_W  APB address
//  psel         out  1       APB select
//  penable      out  1       APB enable
//  pwrite       out  1       APB direction
//  pwdata       out  DATA_W  APB write data; 0 on reads
//  prdata       in   DATA_W  APB read data
//  pready       in   1       APB ready
//  pslverr      in   1       APB slave error
// BEHAVIOUR
//  Reset while preset=1: state IDLE, all outputs 0 (req_ready is gated low), wait counter 0.
//  Release: req_ready=1 from the first clock edge after preset deasserts.
//  All APB outputs and rsp_* are registered.
//  FSM IDLE->SETUP->ACCESS->RESP->IDLE:
//   IDLE: req_ready=1, psel=0, penable=0.
//     On req_valid&req_ready: latch addr, wdata, write into paddr/pwdata/pwrite; go to SETUP.
//   SETUP (1 cycle): psel=1, penable=0; go to ACCESS unconditionally.
//   ACCESS: psel=1, penable=1.
//     pready=1: capture pslverr and, for reads, prdata; drop psel/penable; go to RESP.
//     pready=0: increment wait counter.
//   RESP: rsp_valid=1 with rdata/err/timeout stable.
//     On rsp_ready: clear rsp_valid and rsp_*; go to IDLE.
//  req_ready=0 in SETUP, ACCESS and RESP. The minimum idle gap (psel=0) between transfers is 2 cycles (RESP, IDLE).
//  Latency with zero waits: accept at edge N; psel=1 from N+1; penable=1 from N+2; rsp_valid=1 from N+3.
//  paddr/pwrite/pwdata stable from SETUP through ACCESS end. paddr/pwrite hold their last value when idle.
//  pslverr/prdata are sampled only in ACCESS with pready=1; ignored otherwise.
//  Timeout (TIMEOUT>0):
//   Abort when pready=0 in the TIMEOUT-th ACCESS cycle: drop psel/penable and go to RESP with
//   rsp_err=1, rsp_timeout=1, rsp_rdata=0.
//   pready=1 in that same cycle wins, giving a normal completion.
//   Counter width $clog2(TIMEOUT+1); it clears on entry to SETUP.
//  Reset mid-transfer: psel/penable/rsp_valid go to 0 immediately (async). The transfer is dropped and
//  no response is issued.
// TESTING
//  1. Write addr 0x10, data 0xDEADBEEF, pready tied 1
//     -> psel edge N+1 with penable=0, penable at N+2, rsp_valid at N+3, rsp_err=0.
//  2. Read addr 0x24, 3 wait cycles, then pready=1 with prdata=0xCAFEF00D
//     -> ACCESS lasts 4 cycles, paddr stable at 0x24, rsp_rdata=0xCAFEF00D.
//  3. Write with pready=1, pslverr=1 -> rsp_err=1, rsp_timeout=0, rsp_rdata=0.
//  4. TIMEOUT=16, pready held 0 -> psel drops after 16 ACCESS cycles, rsp_err=1, rsp_timeout=1.
//     Rerun with pready=1 on the 16th cycle -> normal completion, rsp_timeout=0.
//  5. rsp_ready low for 5 cycles while req_valid=1 -> req_ready=0 and no new psel.
//     After the handshake, the next transfer shows psel=0 for at least 2 cycles before rising.
//  6. preset pulsed during ACCESS -> psel/penable/rsp_valid=0 immediately, no response.
//     After release, a read of 0x08 completes normally.

Source files
------------

// File: rtl/apb_master_bridge.sv
// rtl/apb_master_bridge.sv - APB requester bridging a command stream to SETUP/ACCESS transfers with a response channel
module apb_master_bridge #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              pclk,
    input  logic              preset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic [ADDR_W-1:0] paddr,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr
);

    // A zero TIMEOUT still needs a one-bit counter so the declarations stay legal.
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    // Counter value held during the last permitted ACCESS cycle (first cycle sees 0).
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_RESP
    } state_t;

    state_t            state_q,       state_d;
    logic [ADDR_W-1:0] paddr_q,       paddr_d;
    logic              pwrite_q,      pwrite_d;
    logic [DATA_W-1:0] pwdata_q,      pwdata_d;
    logic              psel_q,        psel_d;
    logic              penable_q,     penable_d;
    logic              req_ready_q,   req_ready_d;
    logic              rsp_valid_q,   rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q,   rsp_rdata_d;
    logic              rsp_err_q,     rsp_err_d;
    logic              rsp_timeout_q, rsp_timeout_d;
    logic [CNT_W-1:0]  wait_q,        wait_d;

    logic timeout_hit;

    // The abort fires only when the slave is still stalling in the last allowed ACCESS cycle.
    always_comb begin
        timeout_hit = (TIMEOUT > 0) && (wait_q == LAST_WAIT);
    end

    // Next-state and registered-output computation for the transfer sequencer.
    always_comb begin
        state_d       = state_q;
        paddr_d       = paddr_q;
        pwrite_d      = pwrite_q;
        pwdata_d      = pwdata_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;
        wait_d        = wait_q;

        case (state_q)
            ST_IDLE: begin
                psel_d    = 1'b0;
                penable_d = 1'b0;
                if (req_valid && req_ready_q) begin
                    paddr_d  = req_addr;
                    pwrite_d = req_write;
                    pwdata_d = req_write ? req_wdata : '0;
                    psel_d   = 1'b1;
                    wait_d   = '0;
                    state_d  = ST_SETUP;
                end
            end
            ST_SETUP: begin
                penable_d = 1'b1;
                state_d   = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (pready) begin
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_err_d     = pslverr;
                    rsp_timeout_d = 1'b0;
                    rsp_rdata_d   = pwrite_q ? '0 : prdata;
                    state_d       = ST_RESP;
                end else if (timeout_hit) begin
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                    rsp_rdata_d   = '0;
                    state_d       = ST_RESP;
                end else begin
                    wait_d = wait_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d   = 1'b0;
                    rsp_rdata_d   = '0;
                    rsp_err_d     = 1'b0;
                    rsp_timeout_d = 1'b0;
                    state_d       = ST_IDLE;
                end
            end
            default: begin
                psel_d    = 1'b0;
                penable_d = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase

        // Registered ready: stays low in reset and rises on the first edge back in IDLE.
        req_ready_d = (state_d == ST_IDLE);
    end

    // State and output registers; reset clears everything, dropping any transfer in flight.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q       <= ST_IDLE;
            paddr_q       <= '0;
            pwrite_q      <= 1'b0;
            pwdata_q      <= '0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            req_ready_q   <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            wait_q        <= '0;
        end else begin
            state_q       <= state_d;
            paddr_q       <= paddr_d;
            pwrite_q      <= pwrite_d;
            pwdata_q      <= pwdata_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            req_ready_q   <= req_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
            wait_q        <= wait_d;
        end
    end

    // Every port is driven straight from a register.
    always_comb begin
        req_ready   = req_ready_q;
        rsp_valid   = rsp_valid_q;
        rsp_rdata   = rsp_rdata_q;
        rsp_err     = rsp_err_q;
        rsp_timeout = rsp_timeout_q;
        paddr       = paddr_q;
        psel        = psel_q;
        penable     = penable_q;
        pwrite      = pwrite_q;
        pwdata      = pwdata_q;
    end

endmodule
